gate_bist_ctrl: RTL and testbench
=================================

Name: gate_bist_ctrl

Overview:
Built-in self-test sequencer for one external 2-input combinational gate instance (nor_gate or a sibling gate module). On start it drives every input vector to the gate and waits a programmable settle time. It then samples the gate output and compares it against the truth table selected by op_sel. Reports pass/fail, a saturating mismatch count and the first failing vector.

Parameters:
SETTLE_CYC, 2, cycles each vector is held on dut_a/dut_b before dut_out is sampled (legal range >=1)
PASSES, 1, number of full 4-vector sweeps per test (legal range >=1)
ERR_W, 4, width of err_cnt

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin test; sampled only in IDLE
abort  in  1  synchronous abort of a running test
op_sel  in  3  expected function: 0 NOR, 1 NAND, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6/7 illegal
dut_a  out  1  gate input a (registered)
dut_b  out  1  gate input b (registered)
dut_out  in  1  gate output
busy  out  1  test in progress
done  out  1  one-cycle pulse at normal test completion
pass  out  1  1 = last completed test had zero mismatches
err_cnt  out  ERR_W  mismatch count of the current/last test, saturating
fail_vec  out  2  {a,b} of the first mismatch
fail_valid  out  1  fail_vec holds a captured mismatch
cfg_err  out  1  last start carried an illegal op_sel

Behaviour:
- Reset (async, rst_n=0): state IDLE. dut_a, dut_b, busy, done, pass, err_cnt, fail_vec, fail_valid and cfg_err all go to 0. Takes effect immediately, including mid-test.
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE, start=1, legal op_sel:
  - latch op_sel; clear err_cnt, fail_valid, fail_vec, pass, cfg_err
  - vector index=0, pass count=0; go to APPLY; busy=1 from the next cycle
- IDLE, start=1, op_sel 6/7: no sweep. Next cycle cfg_err=1, pass=0 and done pulses once; busy stays 0.
- APPLY (1 cycle): load {dut_a,dut_b}=vector index; settle counter=SETTLE_CYC; go to WAIT.
- WAIT: vector is visible on the ports. Decrement each cycle; at count 1 go to CHECK, so the vector is held SETTLE_CYC cycles before sampling.
- CHECK (1 cycle):
  - compare dut_out with expected(op_sel_latched, a, b)
  - on mismatch: err_cnt+1, saturating at 2^ERR_W-1; if fail_valid=0, capture fail_vec={a,b} and set fail_valid=1
  - advance vector index 00->01->10->11
  - after 11: wrap to 00 and increment pass count; when pass count reaches PASSES go to DONE, else go to APPLY
- Vector cost is SETTLE_CYC+2 cycles (APPLY + SETTLE_CYC WAIT/sample + CHECK); the last CHECK sample is taken from the held value.
- DONE (1 cycle): done=1, busy=0; pass=(err_cnt==0); dut_a/dut_b return to 0; go to IDLE.
- Latency: done pulses exactly 4*PASSES*(SETTLE_CYC+2) cycles after the first cycle busy=1.
- start while busy: ignored. op_sel changes while busy: ignored, since the value is latched.
- abort=1 while busy, in any state:
  - next cycle IDLE, busy=0, dut_a/dut_b=0
  - no done pulse; pass=0
  - err_cnt and fail_vec retain their partial values
- abort and start in the same IDLE cycle: abort wins, no test starts.
- Outputs pass, err_cnt, fail_vec, fail_valid and cfg_err hold until the next accepted start or reset.

Test Plan:
- Good NOR gate, defaults, op_sel=0, start pulse -> vectors 00,01,10,11 each held 2 cycles; done exactly 16 cycles after busy rises; pass=1, err_cnt=0, fail_valid=0.
- dut_out stuck-at-0, op_sel=0 (NOR) -> single mismatch at vector 00; err_cnt=1, fail_vec=00, fail_valid=1, pass=0.
- Good NOR gate, op_sel=1 (NAND), PASSES=2 -> mismatches at 01 and 10 in each pass; err_cnt=4, fail_vec=01, pass=0, done at cycle 32.
- dut_out stuck-at-1, op_sel=4 (XOR), PASSES=8, ERR_W=4 -> 16 mismatches; err_cnt saturates at 15, no wrap; fail_vec=00.
- abort asserted at cycle 5 of a test -> busy=0 next cycle, no done pulse, pass=0, dut_a=dut_b=0. A second start is then accepted and completes normally.
- Illegal and disruptive inputs:
  - op_sel=7 with start -> cfg_err=1 and one done pulse; busy never rises
  - rst_n pulled low mid-WAIT -> all outputs 0 immediately
  - start pulsed while busy -> ignored

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: built-in self-test sequencer for one external 2-input
// combinational gate. On start it walks the four input vectors {a,b} =
// 00,01,10,11 (PASSES times). Each vector is held SETTLE_CYC cycles, then
// the gate output is compared against the truth table selected by op_sel.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a test (sampled only while idle)
//   abort      cancel a running test
//   op_sel     expected function: 0 NOR,1 NAND,2 AND,3 OR,4 XOR,5 XNOR
//   dut_a/b    registered gate inputs
//   dut_out    gate output under test
//   busy       test in progress
//   done       one-cycle pulse at normal completion
//   pass       last completed test had zero mismatches
//   err_cnt    saturating mismatch count
//   fail_vec   {a,b} of the first mismatch, fail_valid marks it captured
//   cfg_err    last start carried an illegal op_sel
module gate_bist_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int PASSES     = 1,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       op_sel,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       fail_vec,
  output logic             fail_valid,
  output logic             cfg_err
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int PW = $clog2(PASSES + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [1:0]       vec_q;
  logic [SW-1:0]    settle_q;
  logic [PW-1:0]    pass_cnt_q;
  logic             dut_a_q, dut_b_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [1:0]       fail_vec_q;
  logic             fail_valid_q, cfg_err_q;
  logic             mismatch;

  function automatic logic expect_bit(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'd0:    return ~(a | b);
      3'd1:    return ~(a & b);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // Gate output is combinational from the registered inputs, so sampling in
  // CHECK sees the value that has been held throughout WAIT.
  assign mismatch = (dut_out != expect_bit(op_q, dut_a_q, dut_b_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      vec_q        <= 2'd0;
      settle_q     <= '0;
      pass_cnt_q   <= '0;
      dut_a_q      <= 1'b0;
      dut_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_vec_q   <= 2'd0;
      fail_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && abort) begin
        // Abort keeps err_cnt/fail_vec as partial results.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        dut_a_q <= 1'b0;
        dut_b_q <= 1'b0;
        pass_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              if (op_sel > 3'd5) begin
                cfg_err_q <= 1'b1;
                pass_q    <= 1'b0;
                done_q    <= 1'b1;
              end else begin
                op_q         <= op_sel;
                err_cnt_q    <= '0;
                fail_vec_q   <= 2'd0;
                fail_valid_q <= 1'b0;
                pass_q       <= 1'b0;
                cfg_err_q    <= 1'b0;
                vec_q        <= 2'd0;
                pass_cnt_q   <= '0;
                busy_q       <= 1'b1;
                state_q      <= S_APPLY;
              end
            end
          end
          S_APPLY: begin
            dut_a_q  <= vec_q[1];
            dut_b_q  <= vec_q[0];
            settle_q <= SW'(SETTLE_CYC);
            state_q  <= S_WAIT;
          end
          S_WAIT: begin
            if (settle_q <= SW'(1)) state_q <= S_CHECK;
            else                    settle_q <= settle_q - SW'(1);
          end
          S_CHECK: begin
            if (mismatch) begin
              if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + ERR_W'(1);
              if (!fail_valid_q) begin
                fail_vec_q   <= {dut_a_q, dut_b_q};
                fail_valid_q <= 1'b1;
              end
            end
            vec_q   <= vec_q + 2'd1;
            state_q <= S_APPLY;
            if (vec_q == 2'b11) begin
              if (pass_cnt_q == PW'(PASSES - 1)) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                pass_q  <= (err_cnt_q == '0) && !mismatch;
                dut_a_q <= 1'b0;
                dut_b_q <= 1'b0;
              end else begin
                pass_cnt_q <= pass_cnt_q + PW'(1);
              end
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dut_a      = dut_a_q;
  assign dut_b      = dut_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: two instances (default parameters, and
// SETTLE_CYC=3/PASSES=2/ERR_W=2) share stimulus; each drives its own
// modelled gate whose behaviour is a 4-entry truth table gate_tt[{a,b}].
module tb_gate_bist_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [2:0] op_sel = 3'd0;
  logic [3:0] gate_tt = 4'b0001;

  logic a0, b0, o0, busy0, done0, pass0, fvok0, cfg0;
  logic [3:0] err0;
  logic [1:0] fv0;
  logic a1, b1, o1, busy1, done1, pass1, fvok1, cfg1;
  logic [1:0] err1;
  logic [1:0] fv1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign o0 = gate_tt[{a0, b0}];
  assign o1 = gate_tt[{a1, b1}];

  gate_bist_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_sel(op_sel),
    .dut_a(a0), .dut_b(b0), .dut_out(o0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err0), .fail_vec(fv0), .fail_valid(fvok0), .cfg_err(cfg0)
  );

  gate_bist_ctrl #(.SETTLE_CYC(3), .PASSES(2), .ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_sel(op_sel),
    .dut_a(a1), .dut_b(b1), .dut_out(o1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1), .fail_vec(fv1), .fail_valid(fvok1), .cfg_err(cfg1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference truth tables written directly from the function names.
  function automatic logic ref_bit(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'd0:    return !(a || b);
      3'd1:    return !(a && b);
      3'd2:    return a && b;
      3'd3:    return a || b;
      3'd4:    return a != b;
      default: return a == b;
    endcase
  endfunction

  function automatic void ref_model(input logic [2:0] op, input logic [3:0] tt, input int passes,
                                    input int errw, output int err, output int fv, output bit fvalid);
    int miss;
    miss = 0; fv = 0; fvalid = 0;
    for (int v = 0; v < 4; v++) begin
      if (tt[v] != ref_bit(op, v[1], v[0])) begin
        miss++;
        if (!fvalid) begin fv = v; fvalid = 1; end
      end
    end
    err = miss * passes;
    if (err > (1 << errw) - 1) err = (1 << errw) - 1;
  endfunction

  task automatic run_test(input logic [2:0] op, input logic [3:0] tt, input bit glitch);
    int k, rise0, rise1, dn0, dn1, nd0, nd1, e, f;
    bit fvld;
    logic [1:0] seq[$];
    rise0 = -1; rise1 = -1; dn0 = -1; dn1 = -1; nd0 = 0; nd1 = 0;
    gate_tt = tt; op_sel = op; start = 1'b1;
    @(negedge clk); start = 1'b0; k = 1;
    while (k <= 100 && (dn0 < 0 || dn1 < 0)) begin
      if (busy0) begin
        if (rise0 < 0) rise0 = k;
        if (seq.size() == 0 || seq[$] != {a0, b0}) seq.push_back({a0, b0});
      end
      if (busy1 && rise1 < 0) rise1 = k;
      if (done0) begin nd0++; if (dn0 < 0) dn0 = k; end
      if (done1) begin nd1++; if (dn1 < 0) dn1 = k; end
      if (glitch && k == 3) begin start = 1'b1; op_sel = op ^ 3'd1; end
      if (glitch && k == 4) start = 1'b0;
      @(negedge clk); k++;
    end
    repeat (3) begin
      if (done0) nd0++;
      if (done1) nd1++;
      @(negedge clk);
    end
    chk("lat0", dn0 - rise0, 16);
    chk("lat1", dn1 - rise1, 40);
    chk("ndone0", nd0, 1);
    chk("ndone1", nd1, 1);
    chk("idle", {busy0, busy1, a0, b0, a1, b1}, 0);
    chk("seq_len", seq.size(), 4);
    for (int i = 0; i < 4 && i < seq.size(); i++) chk("seq_vec", seq[i], i);
    ref_model(op, tt, 1, 4, e, f, fvld);
    chk("err0", err0, e);
    chk("fvok0", fvok0, fvld);
    chk("fv0", fv0, f);
    chk("pass0", pass0, e == 0);
    chk("cfg0", cfg0, 0);
    ref_model(op, tt, 2, 2, e, f, fvld);
    chk("err1", err1, e);
    chk("fvok1", fvok1, fvld);
    chk("fv1", fv1, f);
    chk("pass1", pass1, e == 0);
  endtask

  task automatic illegal_test(input logic [2:0] op);
    int nb;
    nb = 0;
    op_sel = op; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("ill_cfg", {cfg0, cfg1}, 2'b11);
    chk("ill_done", {done0, done1}, 2'b11);
    chk("ill_pass", {pass0, pass1}, 2'b00);
    repeat (5) begin
      if (busy0 || busy1) nb++;
      @(negedge clk);
      chk("ill_done_once", {done0, done1}, 2'b00);
    end
    chk("ill_busy", nb, 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] tt;
    int         e0;
    int         e1;
    logic [1:0] fv;
    bit         fvalid;
    bit         ps;
  } vec_t;
  vec_t tbl[8];

  initial begin
    // op, gate truth table (bit index {a,b}), err u0, err u1, fail_vec, fail_valid, pass
    tbl[0] = '{3'd0, 4'b0001, 0, 0, 2'd0, 0, 1}; // good NOR
    tbl[1] = '{3'd0, 4'b0000, 1, 2, 2'd0, 1, 0}; // stuck-at-0 vs NOR
    tbl[2] = '{3'd1, 4'b0001, 2, 3, 2'd1, 1, 0}; // NOR gate checked as NAND
    tbl[3] = '{3'd4, 4'b1111, 2, 3, 2'd0, 1, 0}; // stuck-at-1 vs XOR
    tbl[4] = '{3'd2, 4'b1000, 0, 0, 2'd0, 0, 1}; // good AND
    tbl[5] = '{3'd3, 4'b1110, 0, 0, 2'd0, 0, 1}; // good OR
    tbl[6] = '{3'd5, 4'b1001, 0, 0, 2'd0, 0, 1}; // good XNOR
    tbl[7] = '{3'd5, 4'b0110, 3, 3, 2'd0, 1, 0}; // XOR gate vs XNOR: all wrong
    tbl[7].e0 = 4;

    #1;
    chk("rst_u0", {a0, b0, busy0, done0, pass0, err0, fv0, fvok0, cfg0}, 0);
    chk("rst_u1", {a1, b1, busy1, done1, pass1, err1, fv1, fvok1, cfg1}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_test(tbl[i].op, tbl[i].tt, 1'b0);
      chk("tbl_err0", err0, tbl[i].e0);
      chk("tbl_err1", err1, tbl[i].e1);
      chk("tbl_fv", {fv0, fv1}, {tbl[i].fv, tbl[i].fv});
      chk("tbl_fvok", {fvok0, fvok1}, {tbl[i].fvalid, tbl[i].fvalid});
      chk("tbl_pass", {pass0, pass1}, {tbl[i].ps, tbl[i].ps});
    end

    // start and op_sel changes while busy are ignored
    run_test(3'd0, 4'b0001, 1'b1);

    // illegal op_sel
    illegal_test(3'd7);
    illegal_test(3'd6);

    // abort mid-test, then a normal restart
    gate_tt = 4'b0000; op_sel = 3'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_err", err0, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", {busy0, busy1}, 2'b00);
    chk("abort_dut", {a0, b0, a1, b1}, 0);
    chk("abort_pass", {pass0, pass1}, 2'b00);
    chk("abort_keep", {err0, fvok0, fv0}, {4'd1, 1'b1, 2'b00});
    begin
      int nd;
      nd = 0;
      repeat (60) begin
        if (done0 || done1 || busy0 || busy1) nd++;
        @(negedge clk);
      end
      chk("abort_quiet", nd, 0);
    end
    run_test(3'd0, 4'b0001, 1'b0);

    // abort and start together in idle: nothing starts
    op_sel = 3'd0; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_start", {busy0, busy1, done0, done1}, 0);

    // reset mid-WAIT clears everything immediately
    gate_tt = 4'b0000; op_sel = 3'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_state", {a0, b0, busy0, err0}, {2'b01, 1'b1, 4'd1});
    rst_n = 1'b0;
    #1;
    chk("midrst_u0", {a0, b0, busy0, done0, pass0, err0, fv0, fvok0, cfg0}, 0);
    chk("midrst_u1", {a1, b1, busy1, done1, pass1, err1, fv1, fvok1, cfg1}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // randomized tests against the reference model
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 7) == 0)
        illegal_test(3'($urandom_range(6, 7)));
      else
        run_test(3'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
